// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
// Holds the read-mode encodings and the threshold range check used at elaboration.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic bit level_in_range(input int level, input int lo, input int hi);
        return (level >= lo) && (level <= hi);
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read address.
// Contents are not reset; occupancy tracking in the parent decides what is valid.
module fifo_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    parameter int PADDR = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [PADDR-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PADDR-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and FWFT or registered read.
// Sticky overflow/underflow flags are built only when SYNC_FIFO_ERR_EN is defined; otherwise tied to 0.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 16,
    parameter int PADDR    = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 1
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             write_en,
    input  logic             read_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [PADDR:0]   count,
    output logic             overflow,
    output logic             underflow
);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end
    if (!level_in_range(AF_LEVEL, 1, DEPTH)) begin : g_bad_af
        $error("sync_fifo: AF_LEVEL out of range 1..DEPTH");
    end
    if (!level_in_range(AE_LEVEL, 0, DEPTH - 1)) begin : g_bad_ae
        $error("sync_fifo: AE_LEVEL out of range 0..DEPTH-1");
    end

    localparam logic [PADDR:0] DEPTH_C = (PADDR + 1)'(DEPTH);
    localparam logic [PADDR:0] AF_C    = (PADDR + 1)'(AF_LEVEL);
    localparam logic [PADDR:0] AE_C    = (PADDR + 1)'(AE_LEVEL);

    logic [PADDR:0]   wptr_q, wptr_d;
    logic [PADDR:0]   rptr_q, rptr_d;
    logic [PADDR:0]   count_q, count_d;
    logic             read_valid, write_valid;
    logic [WIDTH-1:0] ram_rdata;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign read_valid  = read_en && !empty;
    assign write_valid = write_en && (!full || read_valid);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (write_valid) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (read_valid) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (write_valid && !read_valid) begin
            count_d = count_q + 1'b1;
        end else if (read_valid && !write_valid) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .PADDR (PADDR)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (write_valid),
        .waddr_i (wptr_q[PADDR-1:0]),
        .wdata_i (din),
        .raddr_i (rptr_q[PADDR-1:0]),
        .rdata_o (ram_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign dout = empty ? '0 : ram_rdata;
    end else begin : g_std
        logic [WIDTH-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (read_valid) begin
                dout_d = ram_rdata;
            end
        end

        always_ff @(posedge CLK) begin
            if (rst) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign dout = dout_q;
    end

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q | (write_en & ~write_valid);
        underflow_d = underflow_q | (read_en & empty);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one FWFT instance (a) and one registered-read instance (b).
// Expected values are hand-derived; the wrap test tracks order with a small queue.
module tb_sync_fifo;

    localparam bit ERR_EN =
`ifdef SYNC_FIFO_ERR_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        we_a, re_a, we_b, re_b;
    logic [15:0] din_a, din_b;
    logic [15:0] dout_a, dout_b;
    logic        full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
    logic        full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
    logic [3:0]  count_a, count_b;

    int checks   = 0;
    int failures = 0;

    sync_fifo #(.DEPTH(8), .WIDTH(16), .FWFT(1)) u_fwft (
        .CLK(clk), .rst(rst), .write_en(we_a), .read_en(re_a), .din(din_a),
        .dout(dout_a), .full(full_a), .empty(empty_a), .almost_full(af_a),
        .almost_empty(ae_a), .count(count_a), .overflow(ovf_a), .underflow(unf_a)
    );

    sync_fifo #(.DEPTH(8), .WIDTH(16), .FWFT(0)) u_std (
        .CLK(clk), .rst(rst), .write_en(we_b), .read_en(re_b), .din(din_b),
        .dout(dout_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
        .almost_empty(ae_b), .count(count_b), .overflow(ovf_b), .underflow(unf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [15:0] exp_a [8];
    logic [15:0] q [$];

    initial begin
        rst = 1'b1;
        we_a = 0; re_a = 0; din_a = '0;
        we_b = 0; re_b = 0; din_b = '0;
        tick();
        tick();
        chk("rst_count_a", 32'(count_a), 32'd0);
        chk("rst_empty_a", 32'(empty_a), 32'd1);
        chk("rst_ae_a", 32'(ae_a), 32'd1);
        chk("rst_full_a", 32'(full_a), 32'd0);
        chk("rst_af_a", 32'(af_a), 32'd0);
        chk("rst_dout_a", 32'(dout_a), 32'd0);
        chk("rst_ovf_a", 32'(ovf_a), 32'd0);
        chk("rst_unf_a", 32'(unf_a), 32'd0);
        chk("rst_dout_b", 32'(dout_b), 32'd0);
        rst = 1'b0;

        // Fill both instances to full
        for (int i = 1; i <= 8; i++) begin
            we_a = 1; din_a = 16'(i);
            we_b = 1; din_b = 16'(16'h000F + i);
            tick();
            chk("fill_count_a", 32'(count_a), 32'(i));
            chk("fill_full_a", 32'(full_a), 32'(i == 8));
            chk("fill_af_a", 32'(af_a), 32'(i >= 7));
            chk("fill_ae_a", 32'(ae_a), 32'(i <= 1));
            chk("fill_empty_a", 32'(empty_a), 32'd0);
            chk("fill_count_b", 32'(count_b), 32'(i));
        end
        we_b = 0;
        chk("fill_head_a", 32'(dout_a), 32'h0001);
        chk("fill_hold_b", 32'(dout_b), 32'h0000);

        // Ninth write with no read is rejected
        we_a = 1; din_a = 16'h0009;
        tick();
        chk("ovf_count_a", 32'(count_a), 32'd8);
        chk("ovf_full_a", 32'(full_a), 32'd1);
        chk("ovf_flag_a", 32'(ovf_a), 32'(ERR_EN));
        chk("ovf_head_a", 32'(dout_a), 32'h0001);

        // Write + read while full
        we_a = 1; re_a = 1; din_a = 16'hBEEF;
        tick();
        we_a = 0; re_a = 0;
        chk("fullrw_count_a", 32'(count_a), 32'd8);
        chk("fullrw_full_a", 32'(full_a), 32'd1);
        chk("fullrw_head_a", 32'(dout_a), 32'h0002);

        exp_a = '{16'h0002, 16'h0003, 16'h0004, 16'h0005,
                  16'h0006, 16'h0007, 16'h0008, 16'hBEEF};
        for (int k = 0; k < 8; k++) begin
            chk("drain_dout_a", 32'(dout_a), 32'(exp_a[k]));
            re_a = 1;
            tick();
        end
        re_a = 0;
        chk("drain_empty_a", 32'(empty_a), 32'd1);
        chk("drain_dout0_a", 32'(dout_a), 32'd0);
        chk("drain_count_a", 32'(count_a), 32'd0);
        chk("drain_unf_a", 32'(unf_a), 32'd0);
        chk("sticky_ovf_a", 32'(ovf_a), 32'(ERR_EN));

        // Registered read: data one edge after each read
        for (int k = 0; k < 8; k++) begin
            re_b = 1;
            tick();
            chk("std_dout_b", 32'(dout_b), 32'(16'h0010 + k));
            chk("std_count_b", 32'(count_b), 32'(7 - k));
        end
        re_b = 1;
        tick();
        re_b = 0;
        chk("std_hold_b", 32'(dout_b), 32'h0017);
        chk("std_empty_b", 32'(empty_b), 32'd1);
        chk("std_unf_b", 32'(unf_b), 32'(ERR_EN));
        chk("std_ovf_b", 32'(ovf_b), 32'd0);
        tick();
        chk("std_hold2_b", 32'(dout_b), 32'h0017);

        // FWFT single word visible without a read
        we_a = 1; din_a = 16'hA5A5;
        tick();
        we_a = 0;
        chk("fwft_empty_a", 32'(empty_a), 32'd0);
        chk("fwft_dout_a", 32'(dout_a), 32'hA5A5);
        chk("fwft_count_a", 32'(count_a), 32'd1);
        tick();
        chk("fwft_hold_a", 32'(dout_a), 32'hA5A5);
        re_a = 1;
        tick();
        re_a = 0;
        chk("fwft_rd_empty_a", 32'(empty_a), 32'd1);
        chk("fwft_rd_dout_a", 32'(dout_a), 32'd0);

        // Read + write while empty: read rejected, write taken
        we_a = 1; re_a = 1; din_a = 16'h1234;
        tick();
        re_a = 0;
        chk("emptyrw_count_a", 32'(count_a), 32'd1);
        chk("emptyrw_dout_a", 32'(dout_a), 32'h1234);
        chk("emptyrw_unf_a", 32'(unf_a), 32'(ERR_EN));
        q.push_back(16'h1234);
        for (int k = 0; k < 2; k++) begin
            din_a = 16'(16'h2000 + k);
            q.push_back(din_a);
            tick();
        end
        chk("preload_count_a", 32'(count_a), 32'd3);

        // Streaming through the pointer wrap
        for (int k = 0; k < 20; k++) begin
            chk("wrap_dout_a", 32'(dout_a), 32'(q[0]));
            we_a = 1; re_a = 1; din_a = 16'(16'h3000 + k);
            tick();
            void'(q.pop_front());
            q.push_back(din_a);
            chk("wrap_count_a", 32'(count_a), 32'd3);
        end
        re_a = 0;
        chk("wrap_tail_a", 32'(dout_a), 32'(q[0]));

        // Bring A to count 5, B to a nonzero registered output
        for (int k = 0; k < 2; k++) begin
            we_a = 1; din_a = 16'(16'h4000 + k);
            we_b = 1; din_b = 16'(16'h0040 + k);
            tick();
        end
        we_a = 0; we_b = 0;
        re_b = 1;
        tick();
        re_b = 0;
        chk("pre_rst_count_a", 32'(count_a), 32'd5);
        chk("pre_rst_dout_b", 32'(dout_b), 32'h0040);

        // Mid-stream reset with requests in flight
        rst = 1; we_a = 1; re_a = 1; we_b = 1; re_b = 1;
        din_a = 16'hDEAD; din_b = 16'hDEAD;
        tick();
        rst = 0; we_a = 0; re_a = 0; we_b = 0; re_b = 0;
        chk("mrst_count_a", 32'(count_a), 32'd0);
        chk("mrst_empty_a", 32'(empty_a), 32'd1);
        chk("mrst_ae_a", 32'(ae_a), 32'd1);
        chk("mrst_full_a", 32'(full_a), 32'd0);
        chk("mrst_af_a", 32'(af_a), 32'd0);
        chk("mrst_dout_a", 32'(dout_a), 32'd0);
        chk("mrst_ovf_a", 32'(ovf_a), 32'd0);
        chk("mrst_unf_a", 32'(unf_a), 32'd0);
        chk("mrst_count_b", 32'(count_b), 32'd0);
        chk("mrst_dout_b", 32'(dout_b), 32'd0);
        chk("mrst_unf_b", 32'(unf_b), 32'd0);
        tick();
        chk("post_rst_count_a", 32'(count_a), 32'd0);
        chk("post_rst_empty_b", 32'(empty_b), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
